// File: rtl/serial_stream_bridge.sv
// Bidirectional strobe/ready word bridge: one FIFO per direction with per-word
// repeat, sticky overflow flags and optional local echo of endpoint A.

module serial_stream_bridge #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 32,
    parameter int REPEAT = 1,
    parameter int ECHO   = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       a_rx_data,
    input  logic                   a_rx_strobe,
    output logic [WIDTH-1:0]       a_tx_data,
    output logic                   a_tx_strobe,
    input  logic                   a_tx_ready,
    input  logic [WIDTH-1:0]       b_rx_data,
    input  logic                   b_rx_strobe,
    output logic [WIDTH-1:0]       b_tx_data,
    output logic                   b_tx_strobe,
    input  logic                   b_tx_ready,
    output logic                   a2b_overflow,
    output logic                   b2a_overflow,
    output logic [$clog2(DEPTH):0] a2b_level,
    output logic [WIDTH-1:0]       last_a_rx
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [7:0] LAST_REP = 8'(REPEAT - 1);
    localparam logic [AW:0] FULL_XOR = {1'b1, {AW{1'b0}}};

    // A -> B direction state
    logic [WIDTH-1:0] r_a2bMem [DEPTH];
    logic [AW:0]      r_a2bWptr;
    logic [AW:0]      r_a2bRptr;
    logic [7:0]       r_a2bRep;
    logic             r_a2bPrev;
    logic             r_a2bOvf;
    logic [WIDTH-1:0] r_bTxHold;
    logic             w_a2bFull;
    logic             w_a2bEmpty;
    logic             w_a2bWrite;
    logic             w_a2bEmit;
    logic             w_a2bPop;

    // B -> A direction state, plus the echo holding register
    logic [WIDTH-1:0] r_b2aMem [DEPTH];
    logic [AW:0]      r_b2aWptr;
    logic [AW:0]      r_b2aRptr;
    logic [7:0]       r_b2aRep;
    logic             r_b2aPrev;
    logic             r_b2aOvf;
    logic [WIDTH-1:0] r_aTxHold;
    logic             w_b2aFull;
    logic             w_b2aEmpty;
    logic             w_b2aPush;
    logic [WIDTH-1:0] w_b2aData;
    logic             w_b2aWrite;
    logic             w_b2aEmit;
    logic             w_b2aPop;

    logic             r_echoValid;
    logic [WIDTH-1:0] r_echoData;
    logic             w_echoLoad;
    logic             w_echoDrain;
    logic             w_echoDrop;

    logic [WIDTH-1:0] r_lastARx;

    assign w_a2bFull  = (r_a2bWptr ^ r_a2bRptr) == FULL_XOR;
    assign w_a2bEmpty = r_a2bWptr == r_a2bRptr;
    assign w_a2bWrite = a_rx_strobe && !w_a2bFull;
    assign w_a2bEmit  = reset && !w_a2bEmpty && b_tx_ready && !r_a2bPrev;
    assign w_a2bPop   = w_a2bEmit && (r_a2bRep == LAST_REP);

    assign w_b2aFull  = (r_b2aWptr ^ r_b2aRptr) == FULL_XOR;
    assign w_b2aEmpty = r_b2aWptr == r_b2aRptr;
    assign w_b2aWrite = w_b2aPush && !w_b2aFull;
    assign w_b2aEmit  = reset && !w_b2aEmpty && a_tx_ready && !r_b2aPrev;
    assign w_b2aPop   = w_b2aEmit && (r_b2aRep == LAST_REP);

    // B's own words win the B->A write port; an A echo that collides waits one
    // cycle in the holding register, and a second collision drops the echo.
    always_comb begin
        w_b2aPush   = b_rx_strobe;
        w_b2aData   = b_rx_data;
        w_echoLoad  = 1'b0;
        w_echoDrain = 1'b0;
        w_echoDrop  = 1'b0;
        if (ECHO != 0) begin
            if (b_rx_strobe) begin
                if (a_rx_strobe) begin
                    if (r_echoValid) begin
                        w_echoDrop = 1'b1;
                    end else begin
                        w_echoLoad = 1'b1;
                    end
                end
            end else if (r_echoValid) begin
                w_b2aPush   = 1'b1;
                w_b2aData   = r_echoData;
                w_echoDrain = 1'b1;
                w_echoLoad  = a_rx_strobe;
            end else if (a_rx_strobe) begin
                w_b2aPush = 1'b1;
                w_b2aData = a_rx_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_a2bWrite) begin
            r_a2bMem[r_a2bWptr[AW-1:0]] <= a_rx_data;
        end
        if (w_b2aWrite) begin
            r_b2aMem[r_b2aWptr[AW-1:0]] <= w_b2aData;
        end
    end

    // Full is judged on the pre-pop pointers, so a push into a full FIFO is
    // lost even when the head leaves in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_a2bWptr <= '0;
            r_a2bRptr <= '0;
            r_a2bRep  <= '0;
            r_a2bPrev <= 1'b0;
            r_a2bOvf  <= 1'b0;
            r_bTxHold <= '0;
        end else begin
            r_a2bPrev <= w_a2bEmit;
            if (w_a2bWrite) begin
                r_a2bWptr <= r_a2bWptr + 1'b1;
            end
            if (w_a2bPop) begin
                r_a2bRptr <= r_a2bRptr + 1'b1;
            end
            if (w_a2bEmit) begin
                r_bTxHold <= r_a2bMem[r_a2bRptr[AW-1:0]];
                r_a2bRep  <= w_a2bPop ? 8'd0 : r_a2bRep + 8'd1;
            end
            if (a_rx_strobe && w_a2bFull) begin
                r_a2bOvf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_b2aWptr <= '0;
            r_b2aRptr <= '0;
            r_b2aRep  <= '0;
            r_b2aPrev <= 1'b0;
            r_b2aOvf  <= 1'b0;
            r_aTxHold <= '0;
        end else begin
            r_b2aPrev <= w_b2aEmit;
            if (w_b2aWrite) begin
                r_b2aWptr <= r_b2aWptr + 1'b1;
            end
            if (w_b2aPop) begin
                r_b2aRptr <= r_b2aRptr + 1'b1;
            end
            if (w_b2aEmit) begin
                r_aTxHold <= r_b2aMem[r_b2aRptr[AW-1:0]];
                r_b2aRep  <= w_b2aPop ? 8'd0 : r_b2aRep + 8'd1;
            end
            if ((w_b2aPush && w_b2aFull) || w_echoDrop) begin
                r_b2aOvf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_echoValid <= 1'b0;
            r_echoData  <= '0;
            r_lastARx   <= '0;
        end else begin
            if (w_echoLoad) begin
                r_echoValid <= 1'b1;
                r_echoData  <= a_rx_data;
            end else if (w_echoDrain) begin
                r_echoValid <= 1'b0;
            end
            if (a_rx_strobe) begin
                r_lastARx <= a_rx_data;
            end
        end
    end

    // The head word is shown directly in the strobe cycle and then held.
    assign b_tx_strobe  = w_a2bEmit;
    assign b_tx_data    = w_a2bEmit ? r_a2bMem[r_a2bRptr[AW-1:0]] : r_bTxHold;
    assign a_tx_strobe  = w_b2aEmit;
    assign a_tx_data    = w_b2aEmit ? r_b2aMem[r_b2aRptr[AW-1:0]] : r_aTxHold;
    assign a2b_overflow = r_a2bOvf;
    assign b2a_overflow = r_b2aOvf;
    assign a2b_level    = r_a2bWptr - r_a2bRptr;
    assign last_a_rx    = r_lastARx;

endmodule

// File: tb/tb_serial_stream_bridge.sv
// Bench for serial_stream_bridge: a default instance (u0) and a small
// DEPTH=4 / REPEAT=3 / ECHO=1 instance (u1), checked against queue models.

module tb_serial_stream_bridge;

    localparam int REP1   = 3;
    localparam int DEPTH1 = 4;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    int   tests = 0;
    int   failed = 0;
    int   cycleCnt = 0;

    logic [7:0] aRxData0 = '0, bRxData0 = '0, aTxData0, bTxData0, lastARx0;
    logic       aRxStrobe0 = 1'b0, bRxStrobe0 = 1'b0, aTxReady0 = 1'b0, bTxReady0 = 1'b0;
    logic       aTxStrobe0, bTxStrobe0, a2bOvf0, b2aOvf0;
    logic [5:0] a2bLevel0;

    logic [7:0] aRxData1 = '0, bRxData1 = '0, aTxData1, bTxData1, lastARx1;
    logic       aRxStrobe1 = 1'b0, bRxStrobe1 = 1'b0, aTxReady1 = 1'b0, bTxReady1 = 1'b0;
    logic       aTxStrobe1, bTxStrobe1, a2bOvf1, b2aOvf1;
    logic [2:0] a2bLevel1;

    logic [7:0] capB0[$];
    logic [7:0] capB1[$];
    logic [7:0] capA1[$];
    int         timesB1[$];
    int         readyViol = 0;
    int         spaceViol = 0;
    logic       prevB0 = 1'b0, prevB1 = 1'b0, prevA1 = 1'b0;

    serial_stream_bridge u0 (
        .clk(clk), .reset(resetN),
        .a_rx_data(aRxData0), .a_rx_strobe(aRxStrobe0),
        .a_tx_data(aTxData0), .a_tx_strobe(aTxStrobe0), .a_tx_ready(aTxReady0),
        .b_rx_data(bRxData0), .b_rx_strobe(bRxStrobe0),
        .b_tx_data(bTxData0), .b_tx_strobe(bTxStrobe0), .b_tx_ready(bTxReady0),
        .a2b_overflow(a2bOvf0), .b2a_overflow(b2aOvf0),
        .a2b_level(a2bLevel0), .last_a_rx(lastARx0)
    );

    serial_stream_bridge #(.WIDTH(8), .DEPTH(DEPTH1), .REPEAT(REP1), .ECHO(1)) u1 (
        .clk(clk), .reset(resetN),
        .a_rx_data(aRxData1), .a_rx_strobe(aRxStrobe1),
        .a_tx_data(aTxData1), .a_tx_strobe(aTxStrobe1), .a_tx_ready(aTxReady1),
        .b_rx_data(bRxData1), .b_rx_strobe(bRxStrobe1),
        .b_tx_data(bTxData1), .b_tx_strobe(bTxStrobe1), .b_tx_ready(bTxReady1),
        .a2b_overflow(a2bOvf1), .b2a_overflow(b2aOvf1),
        .a2b_level(a2bLevel1), .last_a_rx(lastARx1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt++;

    // Record every emission and flag strobes that ignore ready or spacing.
    always @(negedge clk) begin
        if (bTxStrobe0) begin
            capB0.push_back(bTxData0);
            if (!bTxReady0) readyViol++;
            if (prevB0) spaceViol++;
        end
        if (bTxStrobe1) begin
            capB1.push_back(bTxData1);
            timesB1.push_back(cycleCnt);
            if (!bTxReady1) readyViol++;
            if (prevB1) spaceViol++;
        end
        if (aTxStrobe1) begin
            capA1.push_back(aTxData1);
            if (!aTxReady1) readyViol++;
            if (prevA1) spaceViol++;
        end
        prevB0 = bTxStrobe0;
        prevB1 = bTxStrobe1;
        prevA1 = aTxStrobe1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clearCapture();
        capB0.delete();
        capB1.delete();
        capA1.delete();
        timesB1.delete();
        readyViol = 0;
        spaceViol = 0;
    endtask

    task automatic doReset();
        aRxStrobe0 = 1'b0; bRxStrobe0 = 1'b0; aRxStrobe1 = 1'b0; bRxStrobe1 = 1'b0;
        resetN = 1'b0;
        ticks(2);
        resetN = 1'b1;
        clearCapture();
    endtask

    // Expected emission stream: every accepted word repeated rep times.
    task automatic expandRepeat(input logic [7:0] words[$], input int rep, output logic [7:0] stream[$]);
        stream.delete();
        foreach (words[i]) for (int r = 0; r < rep; r++) stream.push_back(words[i]);
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        aTxReady0 = 1'b1; bTxReady0 = 1'b1; aTxReady1 = 1'b1; bTxReady1 = 1'b1;
        tick();
        tests++;
        if ({aTxStrobe0, bTxStrobe0, a2bOvf0, b2aOvf0, aTxStrobe1, bTxStrobe1, a2bOvf1, b2aOvf1} !== 8'h00) begin
            failed++;
            $display("[TB] FAIL reset_flags: got %b required 00000000",
                     {aTxStrobe0, bTxStrobe0, a2bOvf0, b2aOvf0, aTxStrobe1, bTxStrobe1, a2bOvf1, b2aOvf1});
        end
        tests++;
        if ({aTxData0, bTxData0, lastARx0, aTxData1, bTxData1, lastARx1} !== 48'h0) begin
            failed++;
            $display("[TB] FAIL reset_data: got %h required 0",
                     {aTxData0, bTxData0, lastARx0, aTxData1, bTxData1, lastARx1});
        end
        tests++;
        if (a2bLevel0 !== 6'd0 || a2bLevel1 !== 3'd0) begin
            failed++;
            $display("[TB] FAIL reset_level: got %0d/%0d required 0/0", a2bLevel0, a2bLevel1);
        end
        resetN = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] w;
        doReset();
        bTxReady0 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            w = (k == 0) ? 8'h41 : 8'($urandom_range(0, 255));
            aRxData0 = w;
            aRxStrobe0 = 1'b1;
            tick();
            aRxStrobe0 = 1'b0;
            tests++;
            if (bTxStrobe0 !== 1'b1 || bTxData0 !== w) begin
                failed++;
                $display("[TB] FAIL basic_emit: got strobe=%b data=%h required strobe=1 data=%h", bTxStrobe0, bTxData0, w);
            end
            tests++;
            if (lastARx0 !== w) begin
                failed++;
                $display("[TB] FAIL basic_last_a_rx: got %h required %h", lastARx0, w);
            end
            tick();
            tests++;
            if (bTxStrobe0 !== 1'b0 || a2bLevel0 !== 6'd0 || bTxData0 !== w) begin
                failed++;
                $display("[TB] FAIL basic_after: got strobe=%b level=%0d data=%h required 0/0/%h",
                         bTxStrobe0, a2bLevel0, bTxData0, w);
            end
            ticks(2);
        end
    endtask

    task automatic test_repeat();
        logic [7:0] words[$];
        logic [7:0] expStream[$];
        doReset();
        bTxReady1 = 1'b1;
        aTxReady1 = 1'b1;
        words = '{8'h10, 8'h20};
        foreach (words[i]) begin
            aRxData1 = words[i];
            aRxStrobe1 = 1'b1;
            tick();
        end
        aRxStrobe1 = 1'b0;
        ticks(24);
        expandRepeat(words, REP1, expStream);
        tests++;
        if (capB1.size() != expStream.size() || capA1.size() != expStream.size()) begin
            failed++;
            $display("[TB] FAIL repeat_count: got b=%0d a=%0d required %0d", capB1.size(), capA1.size(), expStream.size());
        end
        for (int i = 0; i < expStream.size() && i < capB1.size() && i < capA1.size(); i++) begin
            tests++;
            if (capB1[i] !== expStream[i] || capA1[i] !== expStream[i]) begin
                failed++;
                $display("[TB] FAIL repeat_word%0d: got b=%h a=%h required %h", i, capB1[i], capA1[i], expStream[i]);
            end
        end
        for (int i = 1; i < timesB1.size(); i++) begin
            tests++;
            if (timesB1[i] - timesB1[i-1] != 2) begin
                failed++;
                $display("[TB] FAIL repeat_spacing%0d: got %0d required 2", i, timesB1[i] - timesB1[i-1]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] words[$];
        logic [7:0] kept[$];
        logic [7:0] expStream[$];
        doReset();
        bTxReady1 = 1'b0;
        aTxReady1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            words.push_back(8'($urandom_range(0, 255)));
            aRxData1 = words[i];
            aRxStrobe1 = 1'b1;
            tick();
        end
        aRxStrobe1 = 1'b0;
        tick();
        tests++;
        if (a2bLevel1 !== 3'(DEPTH1) || a2bOvf1 !== 1'b1) begin
            failed++;
            $display("[TB] FAIL overflow_full: got level=%0d ovf=%b required %0d/1", a2bLevel1, a2bOvf1, DEPTH1);
        end
        bTxReady1 = 1'b1;
        ticks(40);
        for (int i = 0; i < DEPTH1; i++) kept.push_back(words[i]);
        expandRepeat(kept, REP1, expStream);
        tests++;
        if (capB1.size() != expStream.size() || capA1.size() != expStream.size()) begin
            failed++;
            $display("[TB] FAIL overflow_count: got b=%0d a=%0d required %0d", capB1.size(), capA1.size(), expStream.size());
        end
        for (int i = 0; i < expStream.size() && i < capB1.size() && i < capA1.size(); i++) begin
            tests++;
            if (capB1[i] !== expStream[i] || capA1[i] !== expStream[i]) begin
                failed++;
                $display("[TB] FAIL overflow_word%0d: got b=%h a=%h required %h", i, capB1[i], capA1[i], expStream[i]);
            end
        end
        tests++;
        if (a2bLevel1 !== 3'd0 || a2bOvf1 !== 1'b1 || b2aOvf1 !== 1'b1) begin
            failed++;
            $display("[TB] FAIL overflow_sticky: got level=%0d a2b=%b b2a=%b required 0/1/1", a2bLevel1, a2bOvf1, b2aOvf1);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] sent[$];
        doReset();
        bTxReady0 = 1'b1;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    aRxData0 = 8'($urandom_range(0, 255));
                    sent.push_back(aRxData0);
                    aRxStrobe0 = 1'b1;
                    tick();
                    aRxStrobe0 = 1'b0;
                    ticks(int'($urandom_range(3, 5)));
                end
            end
            begin
                for (int t = 0; t < 80; t++) begin
                    ticks(3);
                    bTxReady0 = ~bTxReady0;
                end
            end
        join
        bTxReady0 = 1'b1;
        ticks(30);
        tests++;
        if (capB0.size() != sent.size()) begin
            failed++;
            $display("[TB] FAIL wrap_count: got %0d required %0d", capB0.size(), sent.size());
        end
        for (int i = 0; i < sent.size() && i < capB0.size(); i++) begin
            tests++;
            if (capB0[i] !== sent[i]) begin
                failed++;
                $display("[TB] FAIL wrap_word%0d: got %h required %h", i, capB0[i], sent[i]);
            end
        end
        tests++;
        if (readyViol != 0 || spaceViol != 0) begin
            failed++;
            $display("[TB] FAIL wrap_rules: got ready=%0d spacing=%0d violations required 0/0", readyViol, spaceViol);
        end
        tests++;
        if (a2bOvf0 !== 1'b0 || a2bLevel0 !== 6'd0) begin
            failed++;
            $display("[TB] FAIL wrap_final: got ovf=%b level=%0d required 0/0", a2bOvf0, a2bLevel0);
        end
    endtask

    task automatic test_echo();
        logic [7:0] x0, x1, y0, y1;
        logic [7:0] expA[$];
        logic [7:0] expB[$];
        for (int pass = 0; pass < 2; pass++) begin
            doReset();
            aTxReady1 = 1'b1;
            bTxReady1 = 1'b1;
            x0 = (pass == 0) ? 8'h55 : 8'($urandom_range(0, 255));
            y0 = (pass == 0) ? 8'h66 : 8'($urandom_range(0, 255));
            x1 = 8'($urandom_range(0, 255));
            y1 = 8'($urandom_range(0, 255));
            aRxData1 = x0; bRxData1 = y0;
            aRxStrobe1 = 1'b1; bRxStrobe1 = 1'b1;
            tick();
            if (pass == 1) begin
                aRxData1 = x1; bRxData1 = y1;
                tick();
            end
            aRxStrobe1 = 1'b0; bRxStrobe1 = 1'b0;
            ticks(40);
            if (pass == 0) begin
                expandRepeat('{y0, x0}, REP1, expA);
                expandRepeat('{x0}, REP1, expB);
            end else begin
                expandRepeat('{y0, y1, x0}, REP1, expA);
                expandRepeat('{x0, x1}, REP1, expB);
            end
            tests++;
            if (capA1.size() != expA.size() || capB1.size() != expB.size()) begin
                failed++;
                $display("[TB] FAIL echo%0d_count: got a=%0d b=%0d required %0d/%0d",
                         pass, capA1.size(), capB1.size(), expA.size(), expB.size());
            end
            for (int i = 0; i < expA.size() && i < capA1.size(); i++) begin
                tests++;
                if (capA1[i] !== expA[i]) begin
                    failed++;
                    $display("[TB] FAIL echo%0d_a_word%0d: got %h required %h", pass, i, capA1[i], expA[i]);
                end
            end
            for (int i = 0; i < expB.size() && i < capB1.size(); i++) begin
                tests++;
                if (capB1[i] !== expB[i]) begin
                    failed++;
                    $display("[TB] FAIL echo%0d_b_word%0d: got %h required %h", pass, i, capB1[i], expB[i]);
                end
            end
            tests++;
            if (b2aOvf1 !== 1'(pass) || a2bOvf1 !== 1'b0) begin
                failed++;
                $display("[TB] FAIL echo%0d_flags: got b2a=%b a2b=%b required %0d/0", pass, b2aOvf1, a2bOvf1, pass);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] w;
        doReset();
        bTxReady0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            aRxData0 = 8'($urandom_range(0, 255));
            aRxStrobe0 = 1'b1;
            tick();
        end
        aRxStrobe0 = 1'b0;
        tests++;
        if (a2bLevel0 !== 6'd3) begin
            failed++;
            $display("[TB] FAIL midreset_queued: got %0d required 3", a2bLevel0);
        end
        bTxReady0 = 1'b1;
        resetN = 1'b0;
        #1;
        tests++;
        if (bTxStrobe0 !== 1'b0) begin
            failed++;
            $display("[TB] FAIL midreset_strobe_in_reset: got %b required 0", bTxStrobe0);
        end
        tick();
        resetN = 1'b1;
        #1;
        tests++;
        if (bTxStrobe0 !== 1'b0 || a2bLevel0 !== 6'd0 || a2bOvf0 !== 1'b0 || b2aOvf0 !== 1'b0) begin
            failed++;
            $display("[TB] FAIL midreset_after: got strobe=%b level=%0d ovf=%b%b required 0/0/00",
                     bTxStrobe0, a2bLevel0, a2bOvf0, b2aOvf0);
        end
        ticks(10);
        tests++;
        if (capB0.size() != 0) begin
            failed++;
            $display("[TB] FAIL midreset_no_emit: got %0d strobes required 0", capB0.size());
        end
        w = 8'($urandom_range(0, 255));
        aRxData0 = w;
        aRxStrobe0 = 1'b1;
        tick();
        aRxStrobe0 = 1'b0;
        ticks(5);
        tests++;
        if (capB0.size() != 1 || capB0[0] !== w) begin
            failed++;
            $display("[TB] FAIL midreset_new_word: got %0d words first=%h required 1 word %h",
                     capB0.size(), (capB0.size() > 0) ? capB0[0] : 8'h00, w);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_repeat();
        test_overflow();
        test_wrap();
        test_echo();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
